// File: rtl/dbg_uart_arb_pkg.sv
// Shared debug-subsystem definitions: record geometry, channel limit and
// the arbiter FSM encoding.
package dbg_uart_arb_pkg;

  localparam int DBG_REC_W   = 40;
  localparam int DBG_TAG_LSB = 36;
  localparam int DBG_MAX_CH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ACKW  = 2'd2,
    ST_DRAIN = 2'd3
  } dbg_state_e;

  // Top nibble of a tagged record carries the source channel index.
  function automatic logic [DBG_REC_W-1:0] dbg_tag(
    input logic [DBG_TAG_LSB-1:0] low,
    input logic [2:0]             ch
  );
    dbg_tag = {1'b0, ch, low};
  endfunction

endpackage

// File: rtl/dbg_rr_pick.sv
// Combinational round-robin select: first valid channel at or above the
// pointer, wrapping modulo N.
module dbg_rr_pick
  import dbg_uart_arb_pkg::*;
#(
  parameter int N = 4
)(
  input  logic [N-1:0] i_valid,
  input  logic [2:0]   i_ptr,
  output logic         o_found,
  output logic [2:0]   o_idx
);

  logic [DBG_MAX_CH-1:0] w_valid;
  logic [2:0]            w_cand;

  assign w_valid = DBG_MAX_CH'(i_valid);

  // Scan from the farthest offset down so the nearest candidate wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_cand = 3'((int'(i_ptr) + k) % N);
      if (w_valid[w_cand]) begin
        o_found = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/dbg_uart_arb.sv
// Round-robin sequencer sharing one 40-bit debug UART transmitter among
// up to eight trace sources, tracking the transmitter's delayed ready.
module dbg_uart_arb
  import dbg_uart_arb_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int TAG_EN  = 1,
  parameter int ACK_TMO = 4
)(
  input  logic                       CLK,
  input  logic                       RST_X,
  input  logic [NCH-1:0]             i_req_valid,
  input  logic [NCH*DBG_REC_W-1:0]   i_req_data,
  output logic [NCH-1:0]             o_req_ready,
  output logic                       o_tx_we,
  output logic [DBG_REC_W-1:0]       o_tx_data,
  input  logic                       i_tx_ready,
  output logic                       o_busy,
  output logic [2:0]                 o_grant_id,
  output logic [7:0]                 o_tmo_cnt,
  output dbg_state_e                 o_state
);

  // Handshake: a channel holds valid with stable data until it sees its
  // one-cycle ready pulse; the record is consumed in that cycle.

  dbg_state_e           r_state;
  logic [2:0]           r_ptr;
  logic [2:0]           r_grant;
  logic [NCH-1:0]       r_ready;
  logic                 r_we;
  logic                 r_busy;
  logic [DBG_REC_W-1:0] r_data;
  logic [7:0]           r_tmo_cnt;
  logic [3:0]           r_ack_cnt;

  logic                 w_found;
  logic [2:0]           w_idx;
  logic [DBG_REC_W-1:0] w_rec [DBG_MAX_CH];
  logic [DBG_REC_W-1:0] w_tx_rec;

  dbg_rr_pick #(.N(NCH)) u_pick (
    .i_valid (i_req_valid),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  for (genvar k = 0; k < DBG_MAX_CH; k++) begin : g_rec
    if (k < NCH) begin : g_on
      assign w_rec[k] = i_req_data[k*DBG_REC_W +: DBG_REC_W];
    end else begin : g_off
      assign w_rec[k] = '0;
    end
  end

  assign w_tx_rec = (TAG_EN != 0) ? dbg_tag(w_rec[w_idx][DBG_TAG_LSB-1:0], w_idx)
                                  : w_rec[w_idx];

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_grant   <= '0;
      r_ready   <= '0;
      r_we      <= 1'b0;
      r_busy    <= 1'b0;
      r_data    <= '0;
      r_tmo_cnt <= '0;
      r_ack_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_tx_ready && w_found) begin
            r_ready <= NCH'(1) << w_idx;
            r_we    <= 1'b1;
            r_data  <= w_tx_rec;
            r_grant <= w_idx;
            r_ptr   <= 3'((int'(w_idx) + 1) % NCH);
            r_busy  <= 1'b1;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_ready   <= '0;
          r_we      <= 1'b0;
          r_ack_cnt <= '0;
          r_state   <= ST_ACKW;
        end
        // A write the transmitter never acknowledges is dropped, not retried.
        ST_ACKW: begin
          if (!i_tx_ready) begin
            r_state <= ST_DRAIN;
          end else if (r_ack_cnt + 4'd1 == 4'(ACK_TMO)) begin
            if (r_tmo_cnt != 8'hFF) r_tmo_cnt <= r_tmo_cnt + 8'd1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_ack_cnt <= r_ack_cnt + 4'd1;
          end
        end
        ST_DRAIN: begin
          if (i_tx_ready) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_req_ready = r_ready;
  assign o_tx_we     = r_we;
  assign o_tx_data   = r_data;
  assign o_busy      = r_busy;
  assign o_grant_id  = r_grant;
  assign o_tmo_cnt   = r_tmo_cnt;
  assign o_state     = r_state;

endmodule

// File: tb/tb_dbg_uart_arb.sv
// Scoreboard bench for dbg_uart_arb: per-channel expected queues, a
// cycle-level transmitter model and a negedge monitor.
module tb_dbg_uart_arb;
  import dbg_uart_arb_pkg::*;

  localparam int NCH     = 4;
  localparam int TAG_EN  = 1;
  localparam int ACK_TMO = 4;
  localparam int W       = DBG_REC_W;

  logic             CLK = 1'b0;
  logic             RST_X = 1'b0;
  logic [NCH-1:0]   i_req_valid = '0;
  logic [NCH*W-1:0] i_req_data = '0;
  logic [NCH-1:0]   o_req_ready;
  logic             o_tx_we;
  logic [W-1:0]     o_tx_data;
  logic             i_tx_ready = 1'b1;
  logic             o_busy;
  logic [2:0]       o_grant_id;
  logic [7:0]       o_tmo_cnt;
  dbg_state_e       o_state;

  dbg_uart_arb #(.NCH(NCH), .TAG_EN(TAG_EN), .ACK_TMO(ACK_TMO)) dut (
    .CLK         (CLK),
    .RST_X       (RST_X),
    .i_req_valid (i_req_valid),
    .i_req_data  (i_req_data),
    .o_req_ready (o_req_ready),
    .o_tx_we     (o_tx_we),
    .o_tx_data   (o_tx_data),
    .i_tx_ready  (i_tx_ready),
    .o_busy      (o_busy),
    .o_grant_id  (o_grant_id),
    .o_tmo_cnt   (o_tmo_cnt),
    .o_state     (o_state)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q [NCH][$];   // expected transmitter word per channel
  logic [W-1:0] drv_q [NCH][$];   // raw records still to be offered
  int mode = 0;                   // 0 normal tx, 1 tx never acks, 2 tx held busy
  int frame_len = 20;
  int cyc = 0;
  int mptr = 0;
  int exp_tmo = 0;
  bit model_busy = 1'b0;
  bit sc_lost = 1'b0;
  bit tx_flight = 1'b0;
  int sc = 0;
  int tmo_at = -1;
  int idle_from = 0;
  int ph = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Pending channel with the smallest circular distance from the pointer.
  function automatic int pick(input logic [NCH-1:0] v, input int ptr);
    int best;
    best = NCH;
    pick = -1;
    for (int k = 0; k < NCH; k++) begin
      if (v[k] && ((k - ptr + NCH) % NCH) < best) begin
        best = (k - ptr + NCH) % NCH;
        pick = k;
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send(input int ch, input logic [W-1:0] rec);
    logic [2:0] tag;
    tag = 3'(ch);
    drv_q[ch].push_back(rec);
    exp_q[ch].push_back((TAG_EN != 0) ? {1'b0, tag, rec[35:0]} : rec);
  endtask

  function automatic bit work_left();
    work_left = model_busy || tx_flight;
    for (int k = 0; k < NCH; k++) if (drv_q[k].size() != 0) work_left = 1'b1;
  endfunction

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (work_left() && n < budget) begin
      tick(1);
      n++;
    end
    check("drain_timeout", 64'(n < budget), 64'(1));
    tick(2);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ready"},  o_req_ready, 0);
    check({tag, "_we"},     o_tx_we,     0);
    check({tag, "_data"},   o_tx_data,   0);
    check({tag, "_busy"},   o_busy,      0);
    check({tag, "_grant"},  o_grant_id,  0);
    check({tag, "_tmo"},    o_tmo_cnt,   0);
    check({tag, "_state"},  o_state,     ST_IDLE);
  endtask

  // ---------------- monitor, transmitter model, channel driver ----------------
  initial begin : monitor
    int g;
    bit must;
    dbg_state_e es;
    forever begin
      @(negedge CLK);
      cyc++;
      must = 1'b0;
      if (!RST_X) begin
        mptr = 0;
        model_busy = 1'b0;
        exp_tmo = 0;
        tmo_at = -1;
        idle_from = cyc + 1;
      end else begin
        if (cyc == tmo_at) begin
          model_busy = 1'b0;
          idle_from = cyc;
          if (exp_tmo < 255) exp_tmo++;
          tmo_at = -1;
        end
        must = !model_busy && (cyc >= idle_from + 1) && i_tx_ready && (i_req_valid != '0);
        if (must)             es = ST_ISSUE;
        else if (!model_busy) es = ST_IDLE;
        else if (sc_lost || cyc <= sc + 2) es = ST_ACKW;
        else                  es = ST_DRAIN;
        check("tx_we", o_tx_we, must);
        check("busy", o_busy, must || model_busy);
        check("state", o_state, es);
        check("tmo_cnt", o_tmo_cnt, exp_tmo);
        if (must) begin
          g = pick(i_req_valid, mptr);
          if (g >= 0 && exp_q[g].size() != 0) begin
            check("grant_id", o_grant_id, g);
            check("req_ready", o_req_ready, 64'(1) << g);
            check("tx_data", o_tx_data, exp_q[g][0]);
            void'(exp_q[g].pop_front());
            void'(drv_q[g].pop_front());
            mptr = (g + 1) % NCH;
          end
          model_busy = 1'b1;
          sc = cyc;
          sc_lost = (mode == 1);
          if (mode == 1) tmo_at = cyc + 1 + ACK_TMO;
        end else begin
          check("req_ready_quiet", o_req_ready, 0);
        end
      end
      // transmitter: ready falls two cycles after the strobe, rises after the frame
      if (tx_flight) begin
        ph++;
        if (ph == 2) i_tx_ready = 1'b0;
        else if (ph >= 2 + frame_len) begin
          i_tx_ready = 1'b1;
          tx_flight = 1'b0;
          if (model_busy) begin
            model_busy = 1'b0;
            idle_from = cyc + 1;
          end
        end
      end else begin
        i_tx_ready = (mode != 2);
      end
      if (must && mode == 0) begin
        tx_flight = 1'b1;
        ph = 0;
      end
      for (int k = 0; k < NCH; k++) begin
        i_req_valid[k] = (drv_q[k].size() != 0);
        i_req_data[k*W +: W] = (drv_q[k].size() != 0) ? drv_q[k][0] : '0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int n;
    RST_X = 1'b0;
    tick(3);
    check_zero_outputs("reset");
    RST_X = 1'b1;
    tick(2);

    // single tagged request on channel 2
    frame_len = 20;
    send(2, 40'h00_1234_5678);
    wait_idle(200);

    // all channels continuously valid
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < NCH; k++) send(k, {8'($urandom), 32'($urandom)});
    wait_idle(600);

    // long frame: full ISSUE/ACKW/DRAIN walk
    frame_len = 50;
    send(1, {8'($urandom), 32'($urandom)});
    wait_idle(200);

    // transmitter busy from elsewhere while a request waits
    mode = 2;
    send(1, {8'($urandom), 32'($urandom)});
    tick(10);
    mode = 0;
    wait_idle(200);

    // randomized traffic with short frames
    frame_len = 6;
    for (int i = 0; i < 40; i++) begin
      send($urandom_range(0, NCH-1), {8'($urandom), 32'($urandom)});
      tick($urandom_range(0, 6));
    end
    wait_idle(3000);

    // lost writes until the timeout counter saturates
    mode = 1;
    for (int i = 0; i < 300; i++) send(i % NCH, {8'(i), 32'($urandom)});
    wait_idle(3000);
    check("tmo_saturated", o_tmo_cnt, 255);
    mode = 0;

    // asynchronous reset in the middle of DRAIN
    frame_len = 50;
    send(0, {8'($urandom), 32'($urandom)});
    n = 0;
    while (o_state != ST_DRAIN && n < 100) begin
      tick(1);
      n++;
    end
    check("reach_drain", 64'(n < 100), 64'(1));
    #2;
    RST_X = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    send(3, {8'($urandom), 32'($urandom)});
    tick(2);
    RST_X = 1'b1;
    wait_idle(300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
